serial_subtractor: RTL and testbench

Bit-serial subtractor built around a one-bit full subtractor cell and a registered borrow. It computes diff = a - b modulo 2^WIDTH for two WIDTH-bit operands, one bit per clock, LSB first. It uses a start/busy/done handshake and pairs with the team's combinational full_adder as the inverse arithmetic primitive. It is a low-area alternative where a parallel subtractor is too large.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b mod 2^WIDTH, LSB first, one full-subtractor cell
// and a registered borrow; result and final borrow held until next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbit;
    logic             nbr;

    assign dbit = a_q[0] ^ b_q[0] ^ br_q;
    assign nbr  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {dbit, res_q[WIDTH-1:1]};
                br_d  = nbr;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the result together with the entry into DONE
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {dbit, res_q[WIDTH-1:1]};
                    bout_d  = nbr;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 directed/random/handshake
// cases and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;
    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    serial_subtractor_if #(.WIDTH(8)) i8 ();
    serial_subtractor_if #(.WIDTH(4)) i4 ();

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (i8.slave)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (i4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int unsigned d;
        d = (int'(a) - int'(b)) & 32'hFF;
        return {(a < b), 8'(d)};
    endfunction

    // mode 0: one-cycle start; 1: extra start pulse during RUN; 2: start held through DONE
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int mode,
                       output logic [7:0] d, output logic bo,
                       output int lat, output int busyc, output int extra);
        @(negedge clk);
        i8.start = 1'b1;
        i8.a     = a;
        i8.b     = b;
        @(posedge clk);
        lat   = -1;
        busyc = 0;
        extra = 0;
        for (int e = 0; e <= 24; e++) begin
            @(negedge clk);
            i8.start = (mode == 2) || (mode == 1 && e >= 2 && e <= 4);
            i8.a = 8'($urandom);
            i8.b = 8'($urandom);
            if (i8.busy) busyc++;
            if (i8.done) begin
                lat = e;
                break;
            end
            @(posedge clk);
        end
        d  = i8.diff;
        bo = i8.bout;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) i8.start = 1'b0;
            if (i8.done) extra++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] d, output logic bo, output logic seen);
        @(negedge clk);
        i4.start = 1'b1;
        i4.a     = a;
        i4.b     = b;
        @(posedge clk);
        seen = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            @(negedge clk);
            i4.start = 1'b0;
            if (i4.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        d  = i4.diff;
        bo = i4.bout;
    endtask

    vec_t       tbl[5];
    logic [7:0] d8;
    logic       bo8;
    logic [8:0] exp9;
    int         lat, busyc, extra;
    logic [7:0] ha[64];
    logic [7:0] hb[64];
    int         last, ndone;
    logic [7:0] lastdiff;
    logic [3:0] d4;
    logic       bo4, seen4;
    logic [3:0] x4, y4;

    initial begin
        tbl[0] = '{8'h5A, 8'h33, 8'h27, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        tbl[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};

        rst = 1'b1;
        i8.start = 1'b0; i8.a = '0; i8.b = '0;
        i4.start = 1'b0; i4.a = '0; i4.b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(i8.busy), 64'd0);
        check("rst_done", 64'(i8.done), 64'd0);
        check("rst_diff", 64'(i8.diff), 64'd0);
        check("rst_bout", 64'(i8.bout), 64'd0);
        rst = 1'b0;

        // Directed table, including latency and busy length
        for (int i = 0; i < 5; i++) begin
            op8(tbl[i].a, tbl[i].b, 0, d8, bo8, lat, busyc, extra);
            check($sformatf("tbl%0d_diff", i), 64'(d8), 64'(tbl[i].diff));
            check($sformatf("tbl%0d_bout", i), 64'(bo8), 64'(tbl[i].bout));
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd8);
            check($sformatf("tbl%0d_busy", i), 64'(busyc), 64'd8);
            check($sformatf("tbl%0d_extra", i), 64'(extra), 64'd0);
        end

        // Start during RUN and start held through DONE are ignored
        for (int m = 1; m <= 2; m++) begin
            op8(8'h5A, 8'h33, m, d8, bo8, lat, busyc, extra);
            check($sformatf("ign%0d_diff", m), 64'(d8), 64'h27);
            check($sformatf("ign%0d_bout", m), 64'(bo8), 64'd0);
            check($sformatf("ign%0d_lat", m), 64'(lat), 64'd8);
            check($sformatf("ign%0d_extra", m), 64'(extra), 64'd0);
        end

        // Random operands against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, 0, d8, bo8, lat, busyc, extra);
            exp9 = ref8(ra, rb);
            check("rnd_diff", 64'(d8), 64'(exp9[7:0]));
            check("rnd_bout", 64'(bo8), 64'(exp9[8]));
            check("rnd_lat", 64'(lat), 64'd8);
        end

        // Back-to-back with start held high; operands change every cycle
        @(negedge clk);
        ha[1] = 8'($urandom);
        hb[1] = 8'($urandom);
        i8.a = ha[1];
        i8.b = hb[1];
        i8.start = 1'b1;
        last = -1;
        ndone = 0;
        lastdiff = '0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (i8.done) begin
                ndone++;
                if (last >= 0) check("b2b_spacing", 64'(n - last), 64'd10);
                exp9 = ref8(ha[n-8], hb[n-8]);
                check("b2b_diff", 64'(i8.diff), 64'(exp9[7:0]));
                check("b2b_bout", 64'(i8.bout), 64'(exp9[8]));
                lastdiff = i8.diff;
                last = n;
            end else if (last >= 0) begin
                check("b2b_stable", 64'(i8.diff), 64'(lastdiff));
            end
            ha[n+1] = 8'($urandom);
            hb[n+1] = 8'($urandom);
            i8.a = ha[n+1];
            i8.b = hb[n+1];
        end
        check("b2b_count", 64'(ndone), 64'd5);
        i8.start = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset during RUN
        @(negedge clk);
        i8.start = 1'b1;
        i8.a = 8'h5A;
        i8.b = 8'h33;
        @(posedge clk);
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(i8.busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(i8.busy), 64'd0);
        check("mid_rst_done", 64'(i8.done), 64'd0);
        check("mid_rst_diff", 64'(i8.diff), 64'd0);
        check("mid_rst_bout", 64'(i8.bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (i8.done) extra++;
        end
        check("post_rst_nodone", 64'(extra), 64'd0);
        check("post_rst_diff", 64'(i8.diff), 64'd0);
        op8(8'h10, 8'h20, 0, d8, bo8, lat, busyc, extra);
        check("post_rst_op_diff", 64'(d8), 64'hF0);
        check("post_rst_op_bout", 64'(bo8), 64'd1);

        // WIDTH=4 exhaustive sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                x4 = 4'(x);
                y4 = 4'(y);
                op4(x4, y4, d4, bo4, seen4);
                check("w4_done", 64'(seen4), 64'd1);
                check("w4_diff", 64'(d4), 64'((x - y) & 15));
                check("w4_bout", 64'(bo4), 64'(x < y));
            end
        end
        $display("Testing Done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
